// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end sharing one registered alu
module alu #(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROLL_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]     op1,
  input  logic [DATA_WIDTH-1:0]     op2,
  input  logic [CONTROLL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0]     aluout,
  output logic                      zero
);
  // result and branch flag decode; code 5 yields the unsigned minimum
  always_comb begin
    aluout = op1;
    zero   = 1'b0;
    case (ctrl)
      CONTROLL_WIDTH'(0): begin aluout = op1 + op2; zero = op1 == op2; end
      CONTROLL_WIDTH'(1): begin aluout = op1 - op2; zero = op1 != op2; end
      CONTROLL_WIDTH'(2): begin aluout = op1 & op2; zero = op1 >= op2; end
      CONTROLL_WIDTH'(3): begin aluout = op1 | op2; zero = $signed(op1) < $signed(op2); end
      CONTROLL_WIDTH'(5): begin aluout = op1 < op2 ? op1 : op2; zero = op1 < op2; end
      CONTROLL_WIDTH'(6): zero = $signed(op1) >= $signed(op2);
      default: ;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROLL_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [DATA_WIDTH-1:0]     req_op1_0,
  input  logic [DATA_WIDTH-1:0]     req_op2_0,
  input  logic [CONTROLL_WIDTH-1:0] req_ctrl_0,
  input  logic [DATA_WIDTH-1:0]     req_op1_1,
  input  logic [DATA_WIDTH-1:0]     req_op2_1,
  input  logic [CONTROLL_WIDTH-1:0] req_ctrl_1,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_zero,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                    state, state_nxt;
  logic                      prio, gid, gnt, accept, done;
  logic [DATA_WIDTH-1:0]     op1_q, op2_q, aluout;
  logic [CONTROLL_WIDTH-1:0] ctrl_q;
  logic                      zero;
  assign gnt    = &req_valid ? prio : req_valid[1];
  assign accept = state == IDLE && |req_valid && !rst;
  assign done   = state == RESP && rsp_ready[gid];
  assign busy   = state != IDLE;
  alu #(.DATA_WIDTH(DATA_WIDTH), .CONTROLL_WIDTH(CONTROLL_WIDTH)) u_alu (
    .op1(op1_q), .op2(op2_q), .ctrl(ctrl_q), .aluout(aluout), .zero(zero)
  );
  // next state and handshake strobes; ready is suppressed while reset is held
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state)
      IDLE: if (accept) begin
        req_ready = gnt ? 2'b10 : 2'b01;
        state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = gid ? 2'b10 : 2'b01;
        state_nxt = done ? IDLE : RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // state, priority pointer, latched request and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      gid      <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      ctrl_q   <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gid    <= gnt;
        op1_q  <= gnt ? req_op1_1 : req_op1_0;
        op2_q  <= gnt ? req_op2_1 : req_op2_0;
        ctrl_q <= gnt ? req_ctrl_1 : req_ctrl_0;
      end
      if (state == EXEC) begin
        rsp_data <= aluout;
        rsp_zero <= zero;
      end
      if (done) prio <= ~gid;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table and sequence checks of the shared-alu arbiter
module tb_alu_arbiter;
  logic        clk = 1'b0, rst, rsp_zero, busy;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] a0, b0, a1, b1, rsp_data;
  logic [2:0]  c0, c1;
  int          checks = 0, errors = 0;
  typedef struct {
    logic        id;
    logic [31:0] a, b;
    logic [2:0]  c;
    logic [31:0] d;
    logic        z;
    int          s;
  } vec_t;
  vec_t tv[14];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1_0(a0), .req_op2_0(b0), .req_ctrl_0(c0),
    .req_op1_1(a1), .req_op2_1(b1), .req_ctrl_1(c1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one transaction from IDLE at a negedge: accept, exec, stall cycles of backpressure, handshake
  task automatic txn(input logic [1:0] v, input logic [31:0] x0, y0, input logic [2:0] k0,
                     input logic [31:0] x1, y1, input logic [2:0] k1,
                     input logic id, input logic [31:0] d, input logic z, input int stall);
    logic [1:0] g;
    g = id ? 2'b10 : 2'b01;
    a0 = x0; b0 = y0; c0 = k0; a1 = x1; b1 = y1; c1 = k1;
    req_valid = v;
    rsp_ready = ~g;
    #1;
    chk("grant", req_ready, g);
    chk("busy_idle", busy, 0);
    @(posedge clk); @(negedge clk);
    a0 = ~x0; b0 = ~y0; a1 = ~x1; b1 = ~y1; c0 = k0 ^ 3'd1; c1 = k1 ^ 3'd1;
    #1;
    chk("ready_exec", req_ready, 0);
    chk("rsp_valid_exec", rsp_valid, 0);
    chk("busy_exec", busy, 1);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("rsp_valid_stall", rsp_valid, g);
      chk("rsp_data_stall", rsp_data, d);
      chk("rsp_zero_stall", rsp_zero, z);
      chk("ready_stall", req_ready, 0);
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 2'b11;
    #1;
    chk("rsp_valid", rsp_valid, g);
    chk("rsp_data", rsp_data, d);
    chk("rsp_zero", rsp_zero, z);
    chk("ready_resp", req_ready, 0);
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    chk("busy_done", busy, 0);
  endtask

  initial begin
    tv[0]  = '{1'b0, 32'd5, 32'd7, 3'd0, 32'd12, 1'b0, 0};
    tv[1]  = '{1'b1, 32'hFFFFFFFF, 32'd1, 3'd6, 32'hFFFFFFFF, 1'b0, 5};
    tv[2]  = '{1'b0, 32'h80000000, 32'd1, 3'd5, 32'd1, 1'b0, 0};
    tv[3]  = '{1'b0, 32'd9, 32'd3, 3'd4, 32'd9, 1'b0, 0};
    tv[4]  = '{1'b1, 32'h0F, 32'hFF, 3'd2, 32'h0F, 1'b0, 0};
    tv[5]  = '{1'b0, 32'd5, 32'd3, 3'd2, 32'd1, 1'b1, 0};
    tv[6]  = '{1'b1, 32'd4, 32'd4, 3'd0, 32'd8, 1'b1, 0};
    tv[7]  = '{1'b0, 32'h80000000, 32'd1, 3'd3, 32'h80000001, 1'b1, 0};
    tv[8]  = '{1'b1, 32'd1, 32'h80000000, 3'd5, 32'd1, 1'b1, 0};
    tv[9]  = '{1'b0, 32'h1234, 32'd5, 3'd7, 32'h1234, 1'b0, 1};
    tv[10] = '{1'b1, 32'd5, 32'd5, 3'd1, 32'd0, 1'b0, 2};
    tv[11] = '{1'b0, 32'd5, 32'd5, 3'd6, 32'd5, 1'b1, 0};
    tv[12] = '{1'b1, 32'hFFFFFFFF, 32'd2, 3'd0, 32'd1, 1'b0, 0};
    tv[13] = '{1'b0, 32'd3, 32'hFFFFFFFE, 3'd6, 32'd3, 1'b1, 0};
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_zero", rsp_zero, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    // both valid after reset, then alternate for six more grants
    txn(2'b11, 32'd3, 32'd5, 3'd1, 32'hF0, 32'h0F, 3'd3, 1'b0, 32'hFFFFFFFE, 1'b1, 0);
    txn(2'b11, 32'd3, 32'd5, 3'd1, 32'hF0, 32'h0F, 3'd3, 1'b1, 32'hFF, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      txn(2'b11, 32'd3, 32'd5, 3'd1, 32'hF0, 32'h0F, 3'd3, 1'(i % 2),
          (i % 2) ? 32'hFF : 32'hFFFFFFFE, (i % 2) ? 1'b0 : 1'b1, 0);
    // single-requester vectors
    for (int i = 0; i < 14; i++)
      if (tv[i].id)
        txn(2'b10, 32'hDEAD, 32'hBEEF, 3'd0, tv[i].a, tv[i].b, tv[i].c, 1'b1, tv[i].d, tv[i].z, tv[i].s);
      else
        txn(2'b01, tv[i].a, tv[i].b, tv[i].c, 32'hDEAD, 32'hBEEF, 3'd0, 1'b0, tv[i].d, tv[i].z, tv[i].s);
    // move priority to requester 1, then abort a response with reset
    txn(2'b01, 32'd1, 32'd1, 3'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd2, 1'b1, 0);
    req_valid = 2'b10;
    a1 = 32'd1; b1 = 32'd1; c1 = 3'd0;
    #1;
    chk("abort_grant", req_ready, 2'b10);
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); @(negedge clk);
    chk("abort_resp_valid", rsp_valid, 2'b10);
    chk("abort_resp_data", rsp_data, 32'd2);
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_data", rsp_data, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    txn(2'b11, 32'd3, 32'd5, 3'd1, 32'hF0, 32'h0F, 3'd3, 1'b0, 32'hFFFFFFFE, 1'b1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
